// File: rtl/ztex_hostif_master.sv
// ztex_hostif_master: host-side master for the ZTEX miner byte-serial link.
//
// Loads a 352-bit work word ({midstate, data}) as 44 bytes, LSB byte first, on read_o.
// The receiver latches each byte when rd_clk_o toggles. Readback pulses wr_start_o so
// the miner snapshots its 128-bit result, then collects 16 bytes from write_i, advancing
// the miner with a wr_clk_o toggle between bytes.
//
// Parameters: HALF_PERIOD (cycles between strobe toggles), WS_CYCLES (wr_start width),
//             SETTLE (cycles from wr_start falling to the first sample).
// Ports:
//   clk_i, reset_ni              clock, asynchronous active-low reset
//   work_valid_i/work_data_i     work word offered; work_ready_o high in idle only
//   rb_req_i                     readback request (idle only, loses to work_valid_i)
//   rb_valid_o/rb_data_o/rb_err_o  one-cycle readback result
//   busy_o, select_o             status / device select
//   rd_clk_o, read_o             load strobe and byte bus
//   wr_start_o, wr_clk_o, write_i  readback snapshot request, shift strobe, byte bus
//
// Optional feature: define ZTEX_HOSTIF_DOUBLE_SAMPLE_EN to sample each readback byte
// twice and flag any disagreement on rb_err_o. Without it, rb_err_o is constant 0.

module ztex_hostif_master #(
    parameter int unsigned HALF_PERIOD = 8,
    parameter int unsigned WS_CYCLES   = 4,
    parameter int unsigned SETTLE      = 16
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         work_valid_i,
    input  logic [351:0] work_data_i,
    output logic         work_ready_o,
    input  logic         rb_req_i,
    output logic         rb_valid_o,
    output logic [127:0] rb_data_o,
    output logic         rb_err_o,
    output logic         busy_o,
    output logic         select_o,
    output logic         rd_clk_o,
    output logic [7:0]   read_o,
    output logic         wr_start_o,
    output logic         wr_clk_o,
    input  logic [7:0]   write_i
);

    localparam logic [7:0] HpLast     = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] WsLast     = 8'(WS_CYCLES - 1);
    localparam logic [7:0] SettleLast = 8'(SETTLE - 1);
    localparam logic [5:0] LdBytes    = 6'd44;
    localparam logic [5:0] RbLastByte = 6'd15;

    typedef enum logic [2:0] {
        StIdle,
        StLdDrive,
        StLdWait,
        StRbStart,
        StRbSettle,
        StRbSample,
        StRbWait,
        StRbDone
    } state_e;

    state_e         state_q;
    logic [351:0]   shift_q;
    logic [5:0]     byte_cnt_q;
    logic [7:0]     wait_cnt_q;
    logic [7:0]     read_q;
    logic           rd_clk_q;
    logic           wr_clk_q;
    logic           wr_start_q;
    logic [127:0]   rb_buf_q;
    logic [127:0]   rb_buf_d;
    logic [127:0]   rb_data_q;
    logic           rb_valid_q;
`ifdef ZTEX_HOSTIF_DOUBLE_SAMPLE_EN
    logic           phase_q;
    logic [7:0]     first_q;
    logic           rb_err_q;
`endif

    // Readback buffer with the byte currently on write_i merged in at its slot.
    always_comb begin
        rb_buf_d = rb_buf_q;
        rb_buf_d[{byte_cnt_q[3:0], 3'b000} +: 8] = write_i;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            wait_cnt_q <= '0;
            read_q     <= '0;
            rd_clk_q   <= 1'b0;
            wr_clk_q   <= 1'b0;
            wr_start_q <= 1'b0;
            rb_buf_q   <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
`ifdef ZTEX_HOSTIF_DOUBLE_SAMPLE_EN
            phase_q    <= 1'b0;
            first_q    <= '0;
            rb_err_q   <= 1'b0;
`endif
        end else begin
            rb_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Work wins; a coincident readback request is simply dropped.
                    if (work_valid_i) begin
                        shift_q    <= work_data_i;
                        read_q     <= work_data_i[7:0];
                        byte_cnt_q <= '0;
                        state_q    <= StLdDrive;
                    end else if (rb_req_i) begin
                        wr_start_q <= 1'b1;
                        wait_cnt_q <= '0;
                        byte_cnt_q <= '0;
`ifdef ZTEX_HOSTIF_DOUBLE_SAMPLE_EN
                        rb_err_q   <= 1'b0;
                        phase_q    <= 1'b0;
`endif
                        state_q    <= StRbStart;
                    end
                end
                StLdDrive: begin
                    // read_q has been stable for this whole cycle before the toggle.
                    if (byte_cnt_q == LdBytes) begin
                        state_q <= StIdle;
                    end else begin
                        rd_clk_q   <= ~rd_clk_q;
                        wait_cnt_q <= '0;
                        state_q    <= StLdWait;
                    end
                end
                StLdWait: begin
                    if (wait_cnt_q == HpLast) begin
                        shift_q    <= shift_q >> 8;
                        read_q     <= shift_q[15:8];
                        byte_cnt_q <= byte_cnt_q + 6'd1;
                        state_q    <= StLdDrive;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                StRbStart: begin
                    if (wait_cnt_q == WsLast) begin
                        wr_start_q <= 1'b0;
                        wait_cnt_q <= '0;
                        state_q    <= StRbSettle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                StRbSettle: begin
                    if (wait_cnt_q == SettleLast) begin
                        wait_cnt_q <= '0;
                        state_q    <= StRbSample;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                StRbSample: begin
`ifdef ZTEX_HOSTIF_DOUBLE_SAMPLE_EN
                    if (!phase_q) begin
                        first_q <= write_i;
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        if (write_i != first_q) begin
                            rb_err_q <= 1'b1;
                        end
`endif
                        rb_buf_q <= rb_buf_d;
                        if (byte_cnt_q == RbLastByte) begin
                            // Last byte: no shift strobe, publish the result.
                            rb_data_q  <= rb_buf_d;
                            rb_valid_q <= 1'b1;
                            state_q    <= StRbDone;
                        end else begin
                            wr_clk_q   <= ~wr_clk_q;
                            wait_cnt_q <= '0;
                            state_q    <= StRbWait;
                        end
`ifdef ZTEX_HOSTIF_DOUBLE_SAMPLE_EN
                    end
`endif
                end
                StRbWait: begin
                    if (wait_cnt_q == HpLast) begin
                        byte_cnt_q <= byte_cnt_q + 6'd1;
                        state_q    <= StRbSample;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                StRbDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign work_ready_o = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign select_o     = reset_ni;
    assign rd_clk_o     = rd_clk_q;
    assign read_o       = read_q;
    assign wr_start_o   = wr_start_q;
    assign wr_clk_o     = wr_clk_q;
    assign rb_valid_o   = rb_valid_q;
    assign rb_data_o    = rb_data_q;
`ifdef ZTEX_HOSTIF_DOUBLE_SAMPLE_EN
    assign rb_err_o     = rb_err_q;
`else
    assign rb_err_o     = 1'b0;
`endif

endmodule

// File: doc/ztex_hostif_master.md
ZTEX_HOSTIF_MASTER -- requirements
Module: ztex_hostif_master

Interface
REQ-001 Parameter HALF_PERIOD, default 8: clk cycles between successive rd_clk/wr_clk toggles; legal range 4..255.
REQ-002 Parameter WS_CYCLES, default 4: clk cycles wr_start is held high; legal range 2..255.
REQ-003 Parameter SETTLE, default 16: clk cycles from wr_start falling to first write-bus sample; legal range 8..255.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 work_valid  input  1  352-bit work word offered.
REQ-007 work_data  input  352  {midstate[255:0], data[95:0]}.
REQ-008 work_ready  output  1  high in IDLE only; transfer on work_valid & work_ready.
REQ-009 rb_req  input  1  readback request; accepted only in IDLE.
REQ-010 rb_valid  output  1  one-cycle pulse, rb_data/rb_err valid.
REQ-011 rb_data  output  128  {golden_nonce_b, hash, nonce, golden_nonce_a}.
REQ-012 rb_err  output  1  readback double-sample mismatch (see Configuration).
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 select  output  1  device select; 1 whenever reset_n is high.
REQ-015 rd_clk  output  1  load strobe; receiver acts on each toggle.
REQ-016 read  output  8  load byte bus.
REQ-017 wr_start  output  1  readback snapshot request.
REQ-018 wr_clk  output  1  readback shift strobe; receiver shifts on each toggle.
REQ-019 write  input  8  readback byte bus from the miner.

Function
REQ-020 The FSM SHALL have states IDLE, LD_DRIVE, LD_WAIT, RB_START, RB_SETTLE, RB_SAMPLE, RB_WAIT and RB_DONE.
REQ-021 In IDLE, work_valid SHALL take priority over a simultaneous rb_req; the rb_req is dropped, not queued.
REQ-022 On work acceptance, work_data SHALL be captured into a 352-bit shift register, the byte counter cleared, and the FSM SHALL go to LD_DRIVE.
REQ-023 LD_DRIVE SHALL drive read = shift[7:0], hold rd_clk for one cycle, then go to LD_WAIT; read stays stable for at least one cycle before each rd_clk toggle.
REQ-024 On entry to LD_WAIT, rd_clk SHALL toggle; the FSM SHALL wait HALF_PERIOD cycles, shift right by 8, and increment the byte counter.
REQ-025 After byte 43 (44 bytes, work_data[7:0] first), the FSM SHALL return to IDLE; otherwise it SHALL return to LD_DRIVE.
REQ-026 rd_clk and wr_clk SHALL keep their levels across transfers; no toggle outside LD_WAIT/RB_WAIT entry.
REQ-027 On rb_req acceptance, the FSM SHALL go to RB_START: wr_start = 1 for exactly WS_CYCLES cycles, then RB_SETTLE.
REQ-028 In RB_SETTLE, wr_start SHALL be 0 for SETTLE cycles, then the FSM SHALL go to RB_SAMPLE.
REQ-029 RB_SAMPLE SHALL capture write into rb_data[8k+7:8k] for byte index k, then go to RB_WAIT, which toggles wr_clk on entry and waits HALF_PERIOD cycles.
REQ-030 After byte 15 is sampled, the FSM SHALL go to RB_DONE without toggling wr_clk; RB_DONE SHALL pulse rb_valid for one cycle and return to IDLE.
REQ-031 rb_data SHALL hold its value until the next RB_DONE.
REQ-032 Counters SHALL be 8 bits for wait counts and 6 bits for the byte index; no wrap is permitted within a transfer.
REQ-033 work_valid and rb_req SHALL be ignored while busy.

Reset
REQ-034 reset_n low SHALL asynchronously force: state IDLE, rd_clk = 0, wr_clk = 0, wr_start = 0, read = 0, rb_data = 0, rb_valid = 0, rb_err = 0, select = 0, and all counters 0.
REQ-035 Reset mid-transfer SHALL abort the transfer with no rb_valid pulse; the first post-reset transfer starts from byte 0.

Configuration
REQ-036 The macro ZTEX_HOSTIF_DOUBLE_SAMPLE_EN controls readback double-sampling.
REQ-037 With ZTEX_HOSTIF_DOUBLE_SAMPLE_EN defined, RB_SAMPLE SHALL last 2 cycles and sample write in both cycles. Any mismatch SHALL set rb_err, which is reported with rb_valid and cleared on the next rb_req acceptance. Each per-byte period grows by 1 cycle.
REQ-038 With the macro undefined, RB_SAMPLE SHALL last 1 cycle and rb_err SHALL be constant 0.

Verification
REQ-039 Load: work_data = 352'h00..2B..0100 (byte i = i) -> 44 rd_clk toggles; read = 8'h00 at the first toggle and 8'h2B at the last; busy high for 44*(HALF_PERIOD+1)+1 cycles; bench receiver model reconstructs an identical 352-bit value.
REQ-040 Readback: model outbuf = 128'h11111111_22222222_33333333_44444444 -> wr_start high 4 cycles; 15 wr_clk toggles; rb_valid once; rb_data = same value; rb_err = 0.
REQ-041 Simultaneous work_valid and rb_req in IDLE -> load runs; wr_start never asserts; no rb_valid.
REQ-042 reset_n low during byte 20 of a load -> outputs reach reset values immediately; after release, a new load sends byte 0 first.
REQ-043 With ZTEX_HOSTIF_DOUBLE_SAMPLE_EN defined, the model changes write between the two samples of byte 5 -> rb_valid with rb_err = 1; the next clean readback gives rb_err = 0.
REQ-044 work_valid held high while busy -> exactly one acceptance per IDLE visit; work_ready = 0 throughout the transfer.
